// File: rtl/bus_seq_pkg.sv
// Shared types and default widths for the serial-bus transaction sequencer and its board tops.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default width constants, mode encodings, sequencer FSM state enum.
package bus_seq_pkg;

  // Default widths shared with the serial_bus tops.
  localparam int BUS_ADDR_W  = 16;
  localparam int BUS_DATA_W  = 8;
  localparam int BUS_DEV_W   = 2;
  localparam int BUS_SLV_AW  = 12;
  localparam int BUS_OFF_W   = 6;
  localparam int BUS_ERR_W   = 8;
  localparam int BUS_TMO_CYC = 4096;

  typedef enum logic [1:0] {
    MODE_SWR   = 2'b00,  // single write
    MODE_SRD   = 2'b01,  // single read
    MODE_BURST = 2'b10,  // burst write then readback
    MODE_RSVD  = 2'b11   // ignored
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACCEPT,
    COMPLETE,
    NEXT,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous button followed by a registered rising-edge pulse.
// Latency: o_rise pulses for one cycle, three clock edges after the raw input rises.
// Backpressure: none; every synchronised rising edge produces exactly one pulse.
// Ports: clk, rstn (sync, active-low), i_async (raw button), o_rise (one-cycle pulse).
module sync_rise_detect (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/bus_txn_sequencer.sv
// On-board transaction driver for one master_interface: single write/read or burst write+readback with compare.
// Latency: sequence starts one cycle after the synchronised start pulse; each transfer takes >= 4 cycles.
// Backpressure: waits on o_m_valid until i_m_ready=1; one outstanding transaction; per-transaction timeout.
// Ports: clk/rstn; i_start, i_mode_sel, i_dev_sel, i_base_off, i_burst_len, i_seed_data (board inputs);
//        o_m_addr, o_m_wdata, o_m_wen, o_m_valid, i_m_rdata, i_m_rvalid, i_m_ready (master_interface side);
//        o_busy, o_done, o_rdata_last, o_err_count, o_timeout, o_pass (status).
module bus_txn_sequencer
  import bus_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = BUS_ADDR_W,
  parameter int DATA_WIDTH  = BUS_DATA_W,
  parameter int DEV_BITS    = BUS_DEV_W,
  parameter int SLV_AW      = BUS_SLV_AW,
  parameter int OFF_W       = BUS_OFF_W,
  parameter int ERR_W       = BUS_ERR_W,
  parameter int TIMEOUT_CYC = BUS_TMO_CYC
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [1:0]            i_mode_sel,
  input  logic [DEV_BITS-1:0]   i_dev_sel,
  input  logic [OFF_W-1:0]      i_base_off,
  input  logic [OFF_W-1:0]      i_burst_len,
  input  logic [DATA_WIDTH-1:0] i_seed_data,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [DATA_WIDTH-1:0] o_m_wdata,
  output logic                  o_m_wen,
  output logic                  o_m_valid,
  input  logic [DATA_WIDTH-1:0] i_m_rdata,
  input  logic                  i_m_rvalid,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata_last,
  output logic [ERR_W-1:0]      o_err_count,
  output logic                  o_timeout,
  output logic                  o_pass
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  seq_state_e r_state, w_state_nxt;

  mode_e                 r_mode;
  logic [DEV_BITS-1:0]   r_dev;
  logic [OFF_W-1:0]      r_base;
  logic [OFF_W-1:0]      r_len;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [OFF_W-1:0]      r_idx;
  logic                  r_rd_phase;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wen;
  logic [TW-1:0]         r_tcnt;
  logic [DATA_WIDTH-1:0] r_rdata_last;
  logic [ERR_W-1:0]      r_err;
  logic                  r_timeout;
  logic                  r_pass;

  logic                  w_rise;
  logic                  w_accept;
  logic                  w_load;
  logic [OFF_W-1:0]      w_idx_nxt;
  logic                  w_phase_nxt;
  logic                  w_capture;
  logic                  w_tmo;
  logic                  w_tmo_hit;
  logic                  w_last;
  mode_e                 w_mode_src;
  logic [DEV_BITS-1:0]   w_dev_src;
  logic [OFF_W-1:0]      w_base_src;
  logic [DATA_WIDTH-1:0] w_seed_src;
  logic [OFF_W-1:0]      w_off_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_wen_nxt;

  sync_rise_detect u_start_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (i_start),
    .o_rise  (w_rise)
  );

  assign w_accept  = (r_state == IDLE) && w_rise && (mode_e'(i_mode_sel) != MODE_RSVD);
  assign w_tmo_hit = (r_tcnt == TW'(TIMEOUT_CYC - 1));
  assign w_last    = (r_mode == MODE_BURST) ? (r_idx == r_len) : 1'b1;

  // The first transfer is set up in the same cycle the inputs are latched,
  // so the address/data builder reads the live inputs while still in IDLE.
  assign w_mode_src = (r_state == IDLE) ? mode_e'(i_mode_sel) : r_mode;
  assign w_dev_src  = (r_state == IDLE) ? i_dev_sel   : r_dev;
  assign w_base_src = (r_state == IDLE) ? i_base_off  : r_base;
  assign w_seed_src = (r_state == IDLE) ? i_seed_data : r_seed;

  // Offset wraps inside the OFF_W field; data wraps at DATA_WIDTH.
  assign w_off_nxt  = w_base_src + w_idx_nxt;
  assign w_data_nxt = w_seed_src + DATA_WIDTH'(w_idx_nxt);
  assign w_wen_nxt  = (w_mode_src == MODE_SWR) || ((w_mode_src == MODE_BURST) && !w_phase_nxt);

  always_comb begin
    w_addr_nxt                       = '0;
    w_addr_nxt[OFF_W-1:0]            = w_off_nxt;
    w_addr_nxt[SLV_AW +: DEV_BITS]   = w_dev_src;
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_m_valid   = 1'b0;
    w_load      = 1'b0;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_rd_phase;
    w_capture   = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_phase_nxt = 1'b0;
        end
      end
      ISSUE: begin
        if (i_m_ready) begin
          o_m_valid   = 1'b1;
          w_state_nxt = ACCEPT;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      ACCEPT: begin
        if (!i_m_ready) begin
          w_state_nxt = COMPLETE;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      COMPLETE: begin
        // Reads finish on m_rvalid even if m_ready rises in the same cycle.
        if (r_wen ? i_m_ready : i_m_rvalid) begin
          w_capture   = !r_wen;
          w_state_nxt = NEXT;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      NEXT: begin
        if (!w_last) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
          w_idx_nxt   = r_idx + 1'b1;
        end else if ((r_mode == MODE_BURST) && !r_rd_phase) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_phase_nxt = 1'b1;
        end else begin
          w_state_nxt = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mode       <= MODE_SWR;
      r_dev        <= '0;
      r_base       <= '0;
      r_len        <= '0;
      r_seed       <= '0;
      r_idx        <= '0;
      r_rd_phase   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wen        <= 1'b0;
      r_tcnt       <= '0;
      r_rdata_last <= '0;
      r_err        <= '0;
      r_timeout    <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode    <= mode_e'(i_mode_sel);
        r_dev     <= i_dev_sel;
        r_base    <= i_base_off;
        r_len     <= i_burst_len;
        r_seed    <= i_seed_data;
        r_err     <= '0;
        r_timeout <= 1'b0;
        r_pass    <= 1'b0;
      end
      // Request fields are loaded once per transfer and held through COMPLETE.
      if (w_load) begin
        r_idx      <= w_idx_nxt;
        r_rd_phase <= w_phase_nxt;
        r_addr     <= w_addr_nxt;
        r_wdata    <= w_data_nxt;
        r_wen      <= w_wen_nxt;
        r_tcnt     <= '0;
      end else if ((r_state == ISSUE) || (r_state == ACCEPT) || (r_state == COMPLETE)) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_capture) begin
        r_rdata_last <= i_m_rdata;
        // r_wdata still holds data_i for this index during the read phase.
        if ((r_mode == MODE_BURST) && r_rd_phase && (i_m_rdata != r_wdata) && (r_err != '1))
          r_err <= r_err + 1'b1;
      end
      if (w_tmo) r_timeout <= 1'b1;
      // Err count is stable on any path into FINISH, so pass is ready with done.
      if ((w_state_nxt == FINISH) && (r_state != FINISH))
        r_pass <= (r_err == '0) && !(r_timeout || w_tmo);
    end
  end

  assign o_m_addr     = r_addr;
  assign o_m_wdata    = r_wdata;
  assign o_m_wen      = r_wen;
  assign o_busy       = (r_state != IDLE) && (r_state != FINISH);
  assign o_done       = (r_state == FINISH);
  assign o_rdata_last = r_rdata_last;
  assign o_err_count  = r_err;
  assign o_timeout    = r_timeout;
  assign o_pass       = r_pass;

endmodule

// File: doc/bus_txn_sequencer.md
Name: bus_txn_sequencer

Overview:
- Parametrised on-board transaction driver for the serial-bus master_interface. It is the successor of the single-shot switch-driven test logic.
- Adds burst write-then-readback over an address range, automatic data compare with error counting, per-transaction timeout, and pass/fail status.
- Sits between board switches/buttons and one master_interface instance; the rest of the dual-bus/UART-bridge fabric is unchanged.

Parameters:
- ADDR_WIDTH, 16, bus address width; must be >= DEV_BITS+SLV_AW.
- DATA_WIDTH, 8, bus data width.
- DEV_BITS, 2, device-select field width.
- SLV_AW, 12, slave memory address field width.
- OFF_W, 6, width of the base-offset and burst-length inputs; must be <= SLV_AW.
- ERR_W, 8, error-counter width.
- TIMEOUT_CYC, 4096, maximum cycles allowed per transaction.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  asynchronous button; a rising edge launches a sequence.
- mode_sel  in  2  00 single write, 01 single read, 10 burst write+readback, 11 reserved.
- dev_sel  in  DEV_BITS  target device.
- base_off  in  OFF_W  first memory offset.
- burst_len  in  OFF_W  transfer count minus 1 (burst mode only).
- seed_data  in  DATA_WIDTH  write data (single) or pattern seed (burst).
- m_addr  out  ADDR_WIDTH  to master_interface maddr.
- m_wdata  out  DATA_WIDTH  to mwdata.
- m_wen  out  1  to wen; 1 = write.
- m_valid  out  1  to mwvalid; one-cycle request pulse.
- m_rdata  in  DATA_WIDTH  from mrdata.
- m_rvalid  in  1  from mrvalid.
- m_ready  in  1  from mready.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end (normal, abort or timeout).
- rdata_last  out  DATA_WIDTH  most recent read data.
- err_count  out  ERR_W  burst compare mismatches, saturating.
- timeout  out  1  sticky; set when a transaction exceeds TIMEOUT_CYC.
- pass  out  1  valid from done until next start: no mismatch and no timeout.

Behaviour:
- Reset: every output 0; FSM to IDLE; synchroniser flops cleared. Reset mid-sequence aborts immediately with no done pulse.
- Start: 2-flop synchroniser plus edge detect. The sequence begins 3 cycles after the raw rising edge.
  - Edges while busy are ignored.
  - mode_sel=11 is ignored: no busy, no done.
- On accepted start, latch all inputs; clear err_count, timeout and pass; set busy.
- Address: m_addr = {zeros, dev_sel, zero-extended offset on SLV_AW bits}. dev_sel occupies bits [SLV_AW+DEV_BITS-1:SLV_AW].
- Index i runs 0..N-1:
  - N = 1 for single modes; N = burst_len+1 for burst.
  - offset_i = (base_off + i) mod 2^OFF_W, so the range wraps inside the offset field.
  - data_i = (seed_data + i) mod 2^DATA_WIDTH.
- FSM states: IDLE, ISSUE, ACCEPT, COMPLETE, NEXT, FINISH.
  - ISSUE: wait for m_ready=1, then drive m_valid=1 for exactly one cycle with m_addr, m_wdata and m_wen stable. m_addr, m_wdata and m_wen hold until COMPLETE exits.
  - ACCEPT: wait for m_ready=0 (request taken).
  - COMPLETE, write: done when m_ready=1.
  - COMPLETE, read: done on the cycle m_rvalid=1. Capture m_rdata into rdata_last. In burst read phase, compare against data_i; on mismatch, err_count+1, saturating at all-ones.
  - If m_rvalid and the m_ready rise occur in the same cycle, the read completes on m_rvalid.
  - NEXT: i+1. If i=N-1, either switch from burst write phase to read phase with i=0, or go to FINISH. Otherwise go to ISSUE.
  - FINISH: busy=0, done=1 for one cycle, pass = (err_count==0 && !timeout); return to IDLE.
- Burst order: all N writes, then all N reads. Single modes skip the phase switch.
- Timeout: a per-transaction counter resets on entry to ISSUE and counts in ISSUE, ACCEPT and COMPLETE. Reaching TIMEOUT_CYC sets timeout and goes to FINISH; remaining transfers are dropped.
- burst_len=0 in burst mode means 1 write plus 1 read.
- At most one outstanding transaction at any time.

Decomposition:
- Shared package bus_seq_pkg holds:
  - mode encodings MODE_SWR, MODE_SRD, MODE_BURST, MODE_RSVD;
  - the FSM state enum;
  - default width constants shared with the serial_bus tops.
- One sub-module: sync_rise_detect (2-flop synchroniser plus registered edge pulse). It is reused for other board buttons.

Test Plan:
- Single write: mode=00, dev=1, off=0x05, seed=0xA5; model master pulses m_ready low for 10 cycles → exactly one m_valid with m_addr=0x1005, m_wdata=0xA5, m_wen=1; done once; pass=1.
- Single read: mode=01, dev=1, off=0x05; model returns 0x3C with m_rvalid → rdata_last=0x3C, m_wen=0, pass=1, err_count=0.
- Burst with loopback memory model: mode=10, dev=2, off=0x3E, len=3, seed=0xFE → writes to offsets 3E,3F,00,01 with data FE,FF,00,01, then 4 reads; err_count=0; pass=1; addresses 0x203E..0x2001 observed.
- Burst with a faulty model corrupting the read at offset 0x3F → err_count=1; pass=0; done once.
- Timeout: model holds m_ready=0 forever after the first request → timeout=1 after TIMEOUT_CYC cycles, done pulse, busy=0, pass=0; the next start clears timeout.
- Robustness: second start edge while busy → ignored. mode=11 → no activity. rstn low mid-burst → all outputs 0, no done, a fresh start works normally.
